// File: rtl/irq_sequencer_if.sv
// ---------------------------------------------------------------------------
// irq_sequencer_if
// Bundles everything between the interrupt sequencer and the five-stage
// pipeline. Signal names are written from the sequencer's point of view:
// i_* flows into the sequencer and o_* flows out of it.
//
//   i_irq            NUM_IRQ  level request lines
//   i_irq_mask       NUM_IRQ  1 = line blocked from selection
//   i_pc_in          PC_W     resume address (next fetch PC)
//   i_ccr_in         CCR_W    live flag register
//   i_rti            1        RTI retired in WB (one-cycle pulse)
//   i_push_ready     1        memory stage accepts a push this cycle
//   o_stall_fetch    1        freeze PC and fetch/decode register
//   o_flush          1        one-cycle bubble into decode/exec
//   o_push_en        1        stack push request
//   o_push_data      DATA_W   word being pushed
//   o_pc_load        1        one-cycle PC redirect strobe
//   o_pc_load_value  PC_W     redirect target
//   o_busy           1        sequence in progress
//   o_irq_id         ID_W     line being or last serviced
//   o_in_service     1        handler active (vector taken, RTI pending)
//
// Modports: master = sequencer side, slave = pipeline side.
// ---------------------------------------------------------------------------
interface irq_sequencer_if #(
    parameter int NUM_IRQ = 4,
    parameter int PC_W    = 32,
    parameter int DATA_W  = 16,
    parameter int CCR_W   = 3
);
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] i_irq;
    logic [NUM_IRQ-1:0] i_irq_mask;
    logic [PC_W-1:0]    i_pc_in;
    logic [CCR_W-1:0]   i_ccr_in;
    logic               i_rti;
    logic               i_push_ready;
    logic               o_stall_fetch;
    logic               o_flush;
    logic               o_push_en;
    logic [DATA_W-1:0]  o_push_data;
    logic               o_pc_load;
    logic [PC_W-1:0]    o_pc_load_value;
    logic               o_busy;
    logic [ID_W-1:0]    o_irq_id;
    logic               o_in_service;

    modport master (
        input  i_irq, i_irq_mask, i_pc_in, i_ccr_in, i_rti, i_push_ready,
        output o_stall_fetch, o_flush, o_push_en, o_push_data, o_pc_load,
               o_pc_load_value, o_busy, o_irq_id, o_in_service
    );

    modport slave (
        output i_irq, i_irq_mask, i_pc_in, i_ccr_in, i_rti, i_push_ready,
        input  o_stall_fetch, o_flush, o_push_en, o_push_data, o_pc_load,
               o_pc_load_value, o_busy, o_irq_id, o_in_service
    );
endinterface

// File: rtl/irq_sequencer.sv
// ---------------------------------------------------------------------------
// irq_sequencer
// Multi-line interrupt sequencer for the five-stage pipeline. Rising edges on
// the request lines are latched as pending; the lowest-index unmasked pending
// line is taken when no handler is active. The sequencer then stalls fetch
// and drains the in-flight instructions, pushes the resume PC (most
// significant word first) and the flags through the memory-stage stack port,
// and finally redirects fetch to the line's vector. The handler stays
// "in service" until RTI retires; handlers do not nest.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      irq_sequencer_if.master (request lines, pipeline controls,
//            stack push port, PC redirect, status)
// ---------------------------------------------------------------------------
module irq_sequencer #(
    parameter int              NUM_IRQ      = 4,
    parameter int              PC_W         = 32,
    parameter int              DATA_W       = 16,
    parameter int              CCR_W        = 3,
    parameter int              DRAIN_CYCLES = 3,
    parameter logic [PC_W-1:0] VEC_BASE     = '0,
    parameter int unsigned     VEC_STRIDE   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    irq_sequencer_if.master bus
);
    localparam int NW   = PC_W / DATA_W;
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int WI_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_PC,
        S_PUSH_CCR,
        S_VECTOR
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [PC_W-1:0]    r_pc_save;
    logic [CCR_W-1:0]   r_ccr_save;
    logic [ID_W-1:0]    r_irq_id;
    logic               r_in_service;
    logic [DC_W-1:0]    r_drain_cnt;
    logic [WI_W-1:0]    r_word_idx;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_clear;
    logic [ID_W-1:0]    w_sel_id;
    logic               w_start;
    logic               w_drain_last;
    logic               w_last_word;
    logic [PC_W-1:0]    w_vec;
    logic [DATA_W-1:0]  w_pc_words [NW];

    assign w_rise       = bus.i_irq & ~r_irq_prev;
    assign w_eligible   = r_pending & ~bus.i_irq_mask;
    assign w_start      = (r_state == S_IDLE) && (|w_eligible) && !r_in_service;
    assign w_drain_last = (r_drain_cnt == DC_W'(DRAIN_CYCLES - 1));
    assign w_last_word  = (r_word_idx == WI_W'(NW - 1));
    assign w_vec        = VEC_BASE + PC_W'(r_irq_id) * PC_W'(VEC_STRIDE);

    assign bus.o_irq_id     = r_irq_id;
    assign bus.o_in_service = r_in_service;

    // Fixed priority: scanning from the top down lets the lowest index win.
    always_comb begin
        w_sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel_id = ID_W'(i);
            end
        end
    end

    // The taken line's pending bit is dropped as the sequence starts; a rising
    // edge in that same cycle is ORed back in afterwards, so it is not lost.
    always_comb begin
        w_clear = '0;
        if (w_start) begin
            w_clear[w_sel_id] = 1'b1;
        end
    end

    // Resume PC split into stack words, index 0 being the most significant.
    always_comb begin
        for (int k = 0; k < NW; k++) begin
            w_pc_words[k] = r_pc_save[(NW - 1 - k) * DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and outputs. All outputs are decoded from the state so an
    // asynchronous reset silences them immediately.
    always_comb begin
        w_next_state        = r_state;
        bus.o_busy          = 1'b0;
        bus.o_stall_fetch   = 1'b0;
        bus.o_flush         = 1'b0;
        bus.o_push_en       = 1'b0;
        bus.o_push_data     = '0;
        bus.o_pc_load       = 1'b0;
        bus.o_pc_load_value = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.o_busy        = 1'b1;
                bus.o_stall_fetch = 1'b1;
                bus.o_flush       = (r_drain_cnt == '0);
                if (w_drain_last) begin
                    w_next_state = S_PUSH_PC;
                end
            end
            S_PUSH_PC: begin
                bus.o_busy        = 1'b1;
                bus.o_stall_fetch = 1'b1;
                bus.o_push_en     = 1'b1;
                bus.o_push_data   = w_pc_words[r_word_idx];
                if (bus.i_push_ready && w_last_word) begin
                    w_next_state = S_PUSH_CCR;
                end
            end
            S_PUSH_CCR: begin
                bus.o_busy        = 1'b1;
                bus.o_stall_fetch = 1'b1;
                bus.o_push_en     = 1'b1;
                bus.o_push_data   = DATA_W'(r_ccr_save);
                if (bus.i_push_ready) begin
                    w_next_state = S_VECTOR;
                end
            end
            S_VECTOR: begin
                bus.o_busy          = 1'b1;
                bus.o_stall_fetch   = 1'b1;
                bus.o_pc_load       = 1'b1;
                bus.o_pc_load_value = w_vec;
                w_next_state        = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: edge detection, pending set, saved context and counters.
    // Flags are sampled in the last drain cycle so they include the effect of
    // every instruction that was allowed to retire.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending    <= '0;
            r_irq_prev   <= '0;
            r_pc_save    <= '0;
            r_ccr_save   <= '0;
            r_irq_id     <= '0;
            r_in_service <= 1'b0;
            r_drain_cnt  <= '0;
            r_word_idx   <= '0;
        end else begin
            r_irq_prev <= bus.i_irq;
            r_pending  <= (r_pending & ~w_clear) | w_rise;
            if (w_start) begin
                r_pc_save <= bus.i_pc_in;
                r_irq_id  <= w_sel_id;
            end
            if (r_state == S_DRAIN) begin
                r_drain_cnt <= w_drain_last ? '0 : r_drain_cnt + DC_W'(1);
                if (w_drain_last) begin
                    r_ccr_save <= bus.i_ccr_in;
                end
            end
            if ((r_state == S_PUSH_PC) && bus.i_push_ready) begin
                r_word_idx <= w_last_word ? '0 : r_word_idx + WI_W'(1);
            end
            // RTI only counts from IDLE; while busy no handler is active anyway.
            if (r_state == S_VECTOR) begin
                r_in_service <= 1'b1;
            end else if (bus.i_rti && (r_state == S_IDLE)) begin
                r_in_service <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_irq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irq_sequencer
// Bench for irq_sequencer. A reference model tracks pending lines as a plain
// bit set and, whenever a service can start, picks the lowest unmasked
// pending line and queues the stack words and vector it must produce. A
// monitor on the falling edge pops those expectations as the DUT pushes and
// redirects, and checks the sequence framing (flush, stalls, length).
// ---------------------------------------------------------------------------
module tb_irq_sequencer;
    localparam int NUM_IRQ    = 4;
    localparam int PC_W       = 32;
    localparam int DATA_W     = 16;
    localparam int CCR_W      = 3;
    localparam int DRAIN      = 3;
    localparam int VEC_BASE   = 0;
    localparam int VEC_STRIDE = 2;
    localparam int NW         = PC_W / DATA_W;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    int checks = 0;
    int fails  = 0;

    logic [DATA_W-1:0] expWords [$];
    logic [PC_W-1:0]   expVec   [$];
    int                expId    [$];
    logic [NUM_IRQ-1:0] modelPending = '0;
    logic [PC_W-1:0]    pcCur;
    logic [CCR_W-1:0]   ccrCur;

    always #5 clk = ~clk;

    irq_sequencer_if #(
        .NUM_IRQ(NUM_IRQ), .PC_W(PC_W), .DATA_W(DATA_W), .CCR_W(CCR_W)
    ) bus ();

    irq_sequencer #(
        .NUM_IRQ(NUM_IRQ), .PC_W(PC_W), .DATA_W(DATA_W), .CCR_W(CCR_W),
        .DRAIN_CYCLES(DRAIN), .VEC_BASE(32'h0), .VEC_STRIDE(VEC_STRIDE)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rstN),
        .bus    (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] allOutputs();
        return {bus.o_stall_fetch, bus.o_flush, bus.o_push_en, bus.o_push_data, bus.o_pc_load,
                bus.o_pc_load_value, bus.o_busy, bus.o_irq_id, bus.o_in_service};
    endfunction

    // Reference: what one service of line id must put on the stack and PC.
    task automatic pushExpect(input int id, input logic [PC_W-1:0] pc, input logic [CCR_W-1:0] ccr);
        for (int w = 0; w < NW; w++) begin
            expWords.push_back(pc[(NW - 1 - w) * DATA_W +: DATA_W]);
        end
        expWords.push_back(DATA_W'(ccr));
        expVec.push_back(PC_W'(VEC_BASE + id * VEC_STRIDE));
        expId.push_back(id);
    endtask

    // One batch: raise the given edges together, then service every pending
    // line in priority order, returning from each handler with an RTI pulse.
    task automatic applyStimulus(input logic [NUM_IRQ-1:0] edges, input logic [NUM_IRQ-1:0] mask,
                                 input logic [NUM_IRQ-1:0] hold, input logic [PC_W-1:0] pc0,
                                 input logic [CCR_W-1:0] ccr0, input bit bpMode,
                                 input bit rtiDrain, input bit randReady);
        logic [NUM_IRQ-1:0] curMask;
        logic [NUM_IRQ-1:0] elig;
        int  id;
        int  cnt;
        bit  first;
        curMask = mask;
        pcCur   = pc0;
        ccrCur  = ccr0;
        bus.i_irq        = '0;
        bus.i_irq_mask   = curMask;
        bus.i_pc_in      = pcCur;
        bus.i_ccr_in     = ccrCur;
        bus.i_push_ready = 1'b1;
        tick();
        bus.i_irq    = edges;
        modelPending = modelPending | edges;
        tick();
        bus.i_irq = edges & hold;
        first = 1'b1;
        while (modelPending != '0) begin
            elig = modelPending & ~curMask;
            if (elig == '0) begin
                repeat (5) begin
                    tick();
                    checkOutput("masked line stays idle", bus.o_busy, 0);
                end
                curMask        = '0;
                bus.i_irq_mask = curMask;
                continue;
            end
            id = 0;
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (elig[i]) id = i;
            end
            modelPending[id] = 1'b0;
            pushExpect(id, pcCur, ccrCur);
            cnt = 0;
            do begin
                tick();
                cnt++;
                bus.i_rti = rtiDrain && first && (cnt == 1);
                if (randReady) bus.i_push_ready = ($urandom_range(0, 3) != 0);
                else bus.i_push_ready = !(bpMode && first && (cnt == 5 || cnt == 6));
                if (cnt == 1) checkOutput("busy one edge after selection", bus.o_busy, 1);
                if (bpMode && first && cnt >= 5 && cnt <= 7) begin
                    checkOutput("backpressure push_en held", bus.o_push_en, 1);
                    checkOutput("backpressure data held", bus.o_push_data, pcCur[DATA_W-1:0]);
                end
            end while (!bus.o_pc_load && cnt < 60);
            checkOutput("pc_load reached", bus.o_pc_load, 1);
            if (!bus.o_pc_load) begin
                modelPending = '0;
                break;
            end
            if (!randReady) checkOutput("cycles to vector", cnt, DRAIN + NW + 2 + ((bpMode && first) ? 2 : 0));
            tick();
            pcCur        = $urandom;
            ccrCur       = CCR_W'($urandom);
            bus.i_pc_in  = pcCur;
            bus.i_ccr_in = ccrCur;
            bus.i_rti    = 1'b1;
            tick();
            bus.i_rti = 1'b0;
            first     = 1'b0;
        end
        bus.i_push_ready = 1'b1;
        // Lines still held high must not re-trigger without a new edge.
        repeat (4) begin
            tick();
            checkOutput("no retrigger from level", bus.o_busy, 0);
        end
    endtask

    task automatic resetMidSequence();
        int cnt;
        bus.i_irq      = '0;
        bus.i_irq_mask = 4'b1000;
        tick();
        bus.i_irq = 4'b1010;
        tick();
        bus.i_irq = '0;
        cnt = 0;
        while (!bus.o_push_en && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput("reached first push before reset", bus.o_push_en, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async reset clears outputs", allOutputs(), 0);
        expWords.delete();
        expVec.delete();
        expId.delete();
        modelPending = '0;
        repeat (2) tick();
        rstN           = 1'b1;
        bus.i_irq_mask = '0;
        repeat (6) begin
            tick();
            checkOutput("idle after reset release", {bus.o_busy, bus.o_push_en}, 0);
        end
    endtask

    // Monitor / scoreboard.
    int busyLen  = 0;
    int stallCnt = 0;
    bit prevBusy = 1'b0;
    bit expInSvc = 1'b0;
    always @(negedge clk) begin
        if (!rstN) begin
            busyLen  = 0;
            stallCnt = 0;
            prevBusy = 1'b0;
            expInSvc = 1'b0;
        end else begin
            if (expInSvc) begin
                checkOutput("in_service after vector", bus.o_in_service, 1);
                expInSvc = 1'b0;
            end
            if (bus.o_busy) begin
                checkOutput("stall while busy", bus.o_stall_fetch, 1);
                checkOutput("flush only first cycle", bus.o_flush, (busyLen == 0));
                if (busyLen < DRAIN) checkOutput("no push while draining", bus.o_push_en, 0);
                if (bus.o_push_en && !bus.i_push_ready) stallCnt++;
                busyLen++;
            end else begin
                checkOutput("idle controls low",
                            {bus.o_stall_fetch, bus.o_flush, bus.o_push_en, bus.o_pc_load}, 0);
                if (prevBusy) begin
                    checkOutput("sequence length", busyLen, DRAIN + NW + 2 + stallCnt);
                    busyLen  = 0;
                    stallCnt = 0;
                end
            end
            if (bus.o_push_en && bus.i_push_ready) begin
                checkOutput("push expected", (expWords.size() != 0), 1);
                if (expWords.size() != 0) checkOutput("push word", bus.o_push_data, expWords.pop_front());
            end
            if (bus.o_pc_load) begin
                checkOutput("vector expected", (expVec.size() != 0), 1);
                if (expVec.size() != 0) begin
                    checkOutput("vector address", bus.o_pc_load_value, expVec.pop_front());
                    checkOutput("irq_id", bus.o_irq_id, expId.pop_front());
                end
                expInSvc = 1'b1;
            end
            prevBusy = bus.o_busy;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.i_irq        = '0;
        bus.i_irq_mask   = '0;
        bus.i_pc_in      = '0;
        bus.i_ccr_in     = '0;
        bus.i_rti        = 1'b0;
        bus.i_push_ready = 1'b1;
        #12;
        checkOutput("reset state", allOutputs(), 0);
        repeat (2) tick();
        rstN = 1'b1;
        tick();

        $display("[TB] single request");
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 32'h0000_0120, 3'b101, 1'b0, 1'b0, 1'b0);

        $display("[TB] priority and deferral");
        applyStimulus(4'b1010, 4'b0000, 4'b0000, 32'hDEAD_0400, 3'b011, 1'b0, 1'b0, 1'b0);

        $display("[TB] backpressure on second PC word");
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 32'h0000_0120, 3'b110, 1'b1, 1'b0, 1'b0);

        $display("[TB] masking with level-held request");
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 32'h1234_5678, 3'b001, 1'b0, 1'b0, 1'b0);

        $display("[TB] rti while idle and during drain");
        bus.i_rti = 1'b1;
        tick();
        bus.i_rti = 1'b0;
        tick();
        checkOutput("rti idle keeps in_service low", {bus.o_in_service, bus.o_busy}, 0);
        applyStimulus(4'b1000, 4'b0000, 4'b0000, 32'h0BAD_F00D, 3'b100, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset mid-sequence");
        resetMidSequence();

        $display("[TB] randomized batches");
        for (int n = 0; n < 25; n++) begin
            applyStimulus(4'($urandom_range(1, 15)),
                          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                          4'($urandom), $urandom, 3'($urandom), 1'b0, 1'b0, 1'b1);
        end

        repeat (3) tick();
        checkOutput("scoreboard drained", expWords.size() + expVec.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
